// File: rtl/repeat_accum_pkg.sv
// Shared types and default widths for the repeated-add accumulation sequencer.
package repeat_accum_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_SUM_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] add_val;
        logic [DEF_CNT_W-1:0]  count;
    } req_t;

endpackage

// File: rtl/repeat_accum_sequencer_if.sv
// Request/result bundle between command producers, the sequencer and the result consumer.
interface repeat_accum_sequencer_if
    import repeat_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SUM_W  = DEF_SUM_W
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_add_val;
    logic [2*CNT_W-1:0]  req_repeat_count;
    logic                out_valid;
    logic                out_ready;
    logic [SUM_W-1:0]    out_total;
    logic                out_id;
    logic                busy;
    logic [15:0]         done_count;

    modport slave (
        input  req_valid, req_add_val, req_repeat_count, out_ready,
        output req_ready, out_valid, out_total, out_id, busy, done_count
    );

    modport master (
        output req_valid, req_add_val, req_repeat_count, out_ready,
        input  req_ready, out_valid, out_total, out_id, busy, done_count
    );
endinterface

// File: rtl/repeat_accum_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the side not granted last.
// Grant is combinational; the last-grant pointer moves only when the caller reports an accept.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);
    logic last_grant_q;

    always_comb begin
        grant_o    = 2'b00;
        grant_id_o = 1'b0;
        case (req_i)
            2'b01: begin grant_o = 2'b01; grant_id_o = 1'b0; end
            2'b10: begin grant_o = 2'b10; grant_id_o = 1'b1; end
            2'b11: begin
                grant_id_o = ~last_grant_q;
                grant_o    = last_grant_q ? 2'b01 : 2'b10;
            end
            default: begin grant_o = 2'b00; grant_id_o = 1'b0; end
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_grant_q <= 1'b1;
        else if (advance_i)
            last_grant_q <= grant_id_o;
    end
endmodule

// File: rtl/repeat_accum_sequencer.sv
// Shares one accumulator between two requesters, adding the latched addend once per clock for N clocks.
// Result appears N+1 cycles after accept (1 for N=0) and is held until out_ready; no requests taken meanwhile.
module repeat_accum_sequencer
    import repeat_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input logic                      clk,
    input logic                      rst,
    repeat_accum_sequencer_if.slave  sq_if
);
    state_e             state_q, state_d;
    logic [DATA_W-1:0]  add_q, add_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               id_q, id_d;
    logic [15:0]        done_q, done_d;

    logic               idle;
    logic [1:0]         grant;
    logic               grant_id;
    logic               accept;
    logic               out_fire;
    logic [DATA_W-1:0]  sel_add;
    logic [CNT_W-1:0]   sel_cnt;

    // Masking requests outside IDLE keeps the arbiter from granting while busy.
    rr_arbiter2 u_arb (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (sq_if.req_valid & {2{idle}}),
        .advance_i  (accept),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign accept   = |(sq_if.req_valid & sq_if.req_ready);
    assign out_fire = sq_if.out_valid & sq_if.out_ready;
    assign sel_add  = grant_id ? sq_if.req_add_val[2*DATA_W-1:DATA_W]
                               : sq_if.req_add_val[DATA_W-1:0];
    assign sel_cnt  = grant_id ? sq_if.req_repeat_count[2*CNT_W-1:CNT_W]
                               : sq_if.req_repeat_count[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (sel_cnt == '0) ? DONE : RUN;
            RUN:     if (rem_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle              = (state_q == IDLE);
        sq_if.req_ready   = grant & {2{idle}};
        sq_if.out_valid   = (state_q == DONE);
        sq_if.busy        = (state_q == RUN) || (state_q == DONE);
        sq_if.out_total   = sum_q;
        sq_if.out_id      = id_q;
        sq_if.done_count  = done_q;
    end

    always_comb begin
        add_d  = add_q;
        rem_d  = rem_q;
        sum_d  = sum_q;
        id_d   = id_q;
        done_d = done_q;
        case (state_q)
            IDLE: if (accept) begin
                add_d = sel_add;
                rem_d = sel_cnt;
                id_d  = grant_id;
                sum_d = '0;
            end
            RUN: begin
                sum_d = sum_q + SUM_W'(add_q);
                rem_d = rem_q - 1'b1;
            end
            DONE: if (out_fire) done_d = done_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_q  <= '0;
            rem_q  <= '0;
            sum_q  <= '0;
            id_q   <= 1'b0;
            done_q <= '0;
        end else begin
            add_q  <= add_d;
            rem_q  <= rem_d;
            sum_q  <= sum_d;
            id_q   <= id_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_repeat_accum_sequencer.sv
// Directed bench: stimulus pushes expected results into a scoreboard, a negedge monitor pops and compares.
module tb_repeat_accum_sequencer;
    import repeat_accum_pkg::*;

    typedef struct packed {
        logic [15:0] total;
        logic        id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    repeat_accum_sequencer_if sq_if ();

    repeat_accum_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .sq_if (sq_if)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sq_if.out_valid && sq_if.out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got total %0d id %0d, expected none",
                         sq_if.out_total, sq_if.out_id);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_total", 32'(sq_if.out_total), 32'(mon_e.total));
                check("out_id", 32'(sq_if.out_id), 32'(mon_e.id));
            end
        end
    end

    task automatic push_exp(input int total, input int r);
        exp_t e;
        e.total = 16'(total);
        e.id    = 1'(r);
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input int r, input req_t rq);
        sq_if.req_add_val[r*8 +: 8]      = rq.add_val;
        sq_if.req_repeat_count[r*4 +: 4] = rq.count;
        sq_if.req_valid[r]               = 1'b1;
    endtask

    task automatic wait_grant(input int r);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sq_if.req_ready[r]) return;
        end
        check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (sq_if.out_valid) begin
                lat = i;
                return;
            end
        end
    endtask

    // Accept one request, optionally disturb its inputs afterwards, and check result latency.
    task automatic run_one(input int r, input req_t rq, input int exp_total,
                           input int exp_lat, input bit scramble);
        int lat;
        drive_req(r, rq);
        wait_grant(r);
        push_exp(exp_total, r);
        @(posedge clk); #1;
        sq_if.req_valid[r] = 1'b0;
        if (scramble) begin
            sq_if.req_add_val[r*8 +: 8]      = 8'd1;
            sq_if.req_repeat_count[r*4 +: 4] = 4'd1;
        end
        wait_out(lat);
        check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst                    = 1'b1;
        sq_if.req_valid        = 2'b00;
        sq_if.req_add_val      = '0;
        sq_if.req_repeat_count = '0;
        sq_if.out_ready        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(sq_if.req_ready), 32'd0);
        check("rst_out_valid", 32'(sq_if.out_valid), 32'd0);
        check("rst_busy", 32'(sq_if.busy), 32'd0);
        check("rst_out_total", 32'(sq_if.out_total), 32'd0);
        check("rst_out_id", 32'(sq_if.out_id), 32'd0);
        check("rst_done_count", 32'(sq_if.done_count), 32'd0);

        // Tie from reset: r0 3x4 then r1 7x2, then a fresh tie goes back to r0.
        drive_req(0, '{add_val: 8'd3, count: 4'd4});
        drive_req(1, '{add_val: 8'd7, count: 4'd2});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("tie_first_grant", 32'(sq_if.req_ready), 32'd1);
        push_exp(12, 0);
        @(posedge clk); #1;
        sq_if.req_valid[0] = 1'b0;
        wait_out(lat);
        check("tie_r0_latency", 32'(lat), 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        check("tie_second_grant", 32'(sq_if.req_ready), 32'd2);
        push_exp(14, 1);
        @(posedge clk); #1;
        sq_if.req_valid[1] = 1'b0;
        wait_out(lat);
        check("tie_r1_latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        drive_req(0, '{add_val: 8'd1, count: 4'd1});
        drive_req(1, '{add_val: 8'd1, count: 4'd1});
        @(negedge clk);
        check("tie_again_r0", 32'(sq_if.req_ready), 32'd1);
        push_exp(1, 0);
        @(posedge clk); #1;
        sq_if.req_valid[0] = 1'b0;
        wait_out(lat);
        @(posedge clk); #1;
        run_one(1, '{add_val: 8'd1, count: 4'd1}, 1, 2, 1'b0);
        check("tie_done_count", 32'(sq_if.done_count), 32'd4);

        // Fresh reset, then the basic and boundary cases.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2_done_count", 32'(sq_if.done_count), 32'd0);
        run_one(0, '{add_val: 8'd10, count: 4'd5}, 50, 6, 1'b0);
        check("basic_done_count", 32'(sq_if.done_count), 32'd1);
        run_one(0, '{add_val: 8'd200, count: 4'd0}, 0, 1, 1'b0);
        check("zero_done_count", 32'(sq_if.done_count), 32'd2);

        // Back-pressure: result must hold and r0 must not be granted until out_ready.
        sq_if.out_ready = 1'b0;
        drive_req(1, '{add_val: 8'd5, count: 4'd3});
        wait_grant(1);
        push_exp(15, 1);
        @(posedge clk); #1;
        sq_if.req_valid[1] = 1'b0;
        drive_req(0, '{add_val: 8'd2, count: 4'd2});
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(sq_if.out_valid), 32'd1);
            check("bp_out_total", 32'(sq_if.out_total), 32'd15);
            check("bp_out_id", 32'(sq_if.out_id), 32'd1);
            check("bp_req_ready", 32'(sq_if.req_ready), 32'd0);
            check("bp_busy", 32'(sq_if.busy), 32'd1);
        end
        @(posedge clk); #1;
        sq_if.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_pending_grant", 32'(sq_if.req_ready), 32'd1);
        push_exp(4, 0);
        @(posedge clk); #1;
        sq_if.req_valid[0] = 1'b0;
        wait_out(lat);
        check("bp_pending_latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        check("bp_done_count", 32'(sq_if.done_count), 32'd4);

        // Maximum operands with the input bus disturbed during RUN.
        run_one(0, '{add_val: 8'd255, count: 4'd15}, 3825, 16, 1'b1);
        check("max_done_count", 32'(sq_if.done_count), 32'd5);

        // Reset during RUN of 9x8: outputs clear at once, in-flight result dropped.
        drive_req(0, '{add_val: 8'd9, count: 4'd8});
        wait_grant(0);
        push_exp(72, 0);
        @(posedge clk); #1;
        sq_if.req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb_q.pop_back());
        #1;
        check("midrst_out_valid", 32'(sq_if.out_valid), 32'd0);
        check("midrst_busy", 32'(sq_if.busy), 32'd0);
        check("midrst_out_total", 32'(sq_if.out_total), 32'd0);
        check("midrst_out_id", 32'(sq_if.out_id), 32'd0);
        check("midrst_done_count", 32'(sq_if.done_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_one(0, '{add_val: 8'd9, count: 4'd8}, 72, 9, 1'b0);
        check("post_rst_done_count", 32'(sq_if.done_count), 32'd1);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
